// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: recovers 8-bit LSB-first frames with optional parity,
// validating the start bit at mid-bit and sampling each following bit at its centre.
module uart_rx_os #(
  parameter int freq       = 450_000_000,
  parameter int baudrate   = 9600,
  parameter int parity_en  = 0,
  parameter int parity_odd = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV_RAW = freq / (baudrate * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = ($clog2(DIV + 1) > 12) ? $clog2(DIV + 1) : 12;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic PEN  = (parity_en != 0);
  localparam logic PODD = (parity_odd != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Handshake: rx_done is a single-cycle strobe with no ready; data_out and the
  // error flags are valid from the rx_done cycle and hold until the next one.

  state_t        state, state_n;
  logic [CW-1:0] tick_cnt;
  logic          os_tick;
  logic          cnt_clr;
  logic          r_m, r_s, r_d;
  logic          fall;
  logic [3:0]    samp, samp_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic [7:0]    data_n;
  logic          done_n, fe_n, pe_n;

  // Two-flop synchroniser resets high so the idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m <= 1'b1;
      r_s <= 1'b1;
      r_d <= 1'b1;
    end else begin
      r_m <= r;
      r_s <= r_m;
      r_d <= r_s;
    end
  end

  assign fall = r_d & ~r_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (cnt_clr || tick_cnt == DIV_M1) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign os_tick = (tick_cnt == DIV_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      samp       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      samp       <= samp_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      par_bit    <= par_n;
      data_out   <= data_n;
      rx_done    <= done_n;
      frame_err  <= fe_n;
      parity_err <= pe_n;
    end
  end

  always_comb begin
    state_n = state;
    samp_n  = samp;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par_bit;
    cnt_clr = 1'b0;
    data_n  = data_out;
    done_n  = 1'b0;
    fe_n    = frame_err;
    pe_n    = parity_err;
    case (state)
      IDLE: begin
        if (fall) begin
          cnt_clr = 1'b1;
          samp_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (os_tick) begin
          if (samp == 4'd7) begin
            samp_n = '0;
            bit_n  = '0;
            // A line back high at mid-start-bit was a glitch: drop it silently.
            state_n = r_s ? IDLE : DATA;
          end else begin
            samp_n = samp + 4'd1;
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          samp_n = samp + 4'd1;
          if (samp == 4'd15) begin
            shift_n = {r_s, shift[7:1]};
            bit_n   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = PEN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (os_tick) begin
          samp_n = samp + 4'd1;
          if (samp == 4'd15) begin
            par_n   = r_s;
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (os_tick) begin
          samp_n = samp + 4'd1;
          if (samp == 4'd15) begin
            state_n = IDLE;
            done_n  = 1'b1;
            data_n  = shift;
            fe_n    = ~r_s;
            pe_n    = PEN & ((^shift) ^ par_bit ^ PODD);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os at DIV=1: three instances cover no parity, even and odd parity;
// expected frames are queued when driven and compared on each rx_done.
module tb_uart_rx_os;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r_a = 1'b1, r_b = 1'b1, r_c = 1'b1;
  int   cyc = 0;

  logic [7:0] data_out_a, data_out_b, data_out_c;
  logic       rx_done_a, rx_done_b, rx_done_c;
  logic       frame_err_a, frame_err_b, frame_err_c;
  logic       parity_err_a, parity_err_b, parity_err_c;
  logic       busy_a, busy_b, busy_c;

  int checks = 0;
  int failures = 0;

  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];
  logic [9:0] exp_q_c[$];
  int         done_t[$];

  uart_rx_os #(.freq(16_000_000), .baudrate(1_000_000), .parity_en(0), .parity_odd(0)) u_a (
    .clk(clk), .rst(rst), .r(r_a), .data_out(data_out_a), .rx_done(rx_done_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .busy(busy_a));

  uart_rx_os #(.freq(16_000_000), .baudrate(1_000_000), .parity_en(1), .parity_odd(0)) u_b (
    .clk(clk), .rst(rst), .r(r_b), .data_out(data_out_b), .rx_done(rx_done_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .busy(busy_b));

  uart_rx_os #(.freq(16_000_000), .baudrate(1_000_000), .parity_en(1), .parity_odd(1)) u_c (
    .clk(clk), .rst(rst), .r(r_c), .data_out(data_out_c), .rx_done(rx_done_c),
    .frame_err(frame_err_c), .parity_err(parity_err_c), .busy(busy_c));

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0: r_a = v;
      1: r_b = v;
      default: r_c = v;
    endcase
  endtask

  function automatic logic get_busy(input int which);
    case (which)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Driver: one frame at 16 clocks per bit, called on a negedge.
  task automatic send(input int which, input logic [7:0] d, input logic p, input logic has_p,
                      input logic stop, input logic exp_pe);
    logic [10:0] bits;
    int n;
    case (which)
      0: exp_q_a.push_back({d, ~stop, exp_pe});
      1: exp_q_b.push_back({d, ~stop, exp_pe});
      default: exp_q_c.push_back({d, ~stop, exp_pe});
    endcase
    bits = has_p ? {stop, p, d, 1'b0} : {1'b0, stop, d, 1'b0};
    n = has_p ? 11 : 10;
    for (int i = 0; i < n; i++) begin
      set_line(which, bits[i]);
      repeat (8) @(negedge clk);
      check($sformatf("busy_%0d_bit%0d", which, i), get_busy(which), 1'b1);
      repeat (8) @(negedge clk);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rx_done_a) begin
      done_t.push_back(cyc);
      if (exp_q_a.size() == 0) check("unexpected_done_a", rx_done_a, 1'b0);
      else check("frame_a", {data_out_a, frame_err_a, parity_err_a}, exp_q_a.pop_front());
    end
    if (rx_done_b) begin
      if (exp_q_b.size() == 0) check("unexpected_done_b", rx_done_b, 1'b0);
      else check("frame_b", {data_out_b, frame_err_b, parity_err_b}, exp_q_b.pop_front());
    end
    if (rx_done_c) begin
      if (exp_q_c.size() == 0) check("unexpected_done_c", rx_done_c, 1'b0);
      else check("frame_c", {data_out_c, frame_err_c, parity_err_c}, exp_q_c.pop_front());
    end
  end

  initial begin
    logic [7:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data_out_a, 8'h00);
    check("rst_done", rx_done_a, 1'b0);
    check("rst_fe", frame_err_a, 1'b0);
    check("rst_pe", parity_err_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("idle_after_clean", busy_a, 1'b0);

    // Glitch rejection
    r_a = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", busy_a, 1'b1);
    r_a = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_idle", busy_a, 1'b0);
    check("glitch_data", data_out_a, 8'h5A);
    repeat (10) @(negedge clk);

    // Framing error, then a held-low line must not start a frame
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    check("break_idle", busy_a, 1'b0);
    check("break_fe_hold", frame_err_a, 1'b1);
    r_a = 1'b1;
    repeat (20) @(negedge clk);
    send(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);

    // Back-to-back frames
    done_t.delete();
    send(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("b2b_count", done_t.size(), 2);
    if (done_t.size() == 2) check("b2b_spacing", done_t[1] - done_t[0], 160);

    // Parity, even then odd
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    send(1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
    send(2, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    send(2, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge clk);

    // Reset during bit 3 of 0xA5
    v = 8'hA5;
    r_a = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      r_a = v[i];
      repeat (16) @(negedge clk);
    end
    r_a = v[3];
    repeat (8) @(negedge clk);
    check("mid_busy", busy_a, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_data", data_out_a, 8'h00);
    check("mid_rst_done", rx_done_a, 1'b0);
    check("mid_rst_fe", frame_err_a, 1'b0);
    check("mid_rst_pe_b", parity_err_b, 1'b0);
    check("mid_rst_data_c", data_out_c, 8'h00);
    repeat (3) @(negedge clk);
    r_a = 1'b1;
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_idle", busy_a, 1'b0);
    send(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) @(negedge clk);

    // Final report
    check("left_a", exp_q_a.size(), 0);
    check("left_b", exp_q_b.size(), 0);
    check("left_c", exp_q_c.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampling UART receiver for the UART subsystem, the receive-side counterpart of the existing transmit path. It recovers 8-bit frames from the asynchronous serial line. It synchronises the line, validates the start bit at mid-bit, and samples each data bit at its centre. It reports each frame with a one-cycle `rx_done` pulse plus framing and parity error flags.

## Interface
- `freq`, default 450_000_000: system clock frequency in Hz.
- `baudrate`, default 9600: line rate in bit/s.
- `parity_en`, default 0: 1 means a parity bit follows the data bits.
- `parity_odd`, default 0: 1 selects odd parity, 0 selects even. Ignored when `parity_en`=0.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `r`  in  1  serial line, idle high, asynchronous to `clk`.
- `data_out`  out  8  last received byte, LSB received first.
- `rx_done`  out  1  one-cycle pulse when `data_out` and the flags update.
- `frame_err`  out  1  stop bit of the last frame sampled 0.
- `parity_err`  out  1  parity mismatch in the last frame; always 0 when `parity_en`=0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Divider:** DIV = freq/(baudrate*16), integer floor, clamped to a minimum of 1.
  - A tick counter (≥12 bits) emits `os_tick` every DIV cycles.
  - The counter is cleared on start detection.
- **Synchroniser:** `r` passes through 2 flops to give `r_s`. The flops reset to 1, so no false start follows reset. A third flop holds `r_s` delayed for falling-edge detection.
- **States:** IDLE, START, DATA, PARITY, STOP. A 4-bit sample counter counts ticks and a 3-bit bit index counts data bits.
  - IDLE: a falling edge on `r_s` clears the divider and sample counter, then goes to START. A line held low without an edge (for example after a break) never starts a frame.
  - START: on the 8th tick, sample `r_s`. If 0, clear the sample counter and go to DATA. If 1 (glitch), go to IDLE with no `rx_done` and no output change.
  - DATA: on every 16th tick, shift `r_s` into the shift register at the MSB side, LSB-first. After bit 7, go to PARITY if `parity_en`, else STOP.
  - PARITY: on the 16th tick, capture the parity bit, then go to STOP.
  - STOP: on the 16th tick, sample the stop bit and go to IDLE. On the next clock:
    - `data_out` takes the shift register value.
    - `frame_err` = ~stop.
    - `parity_err` = (XOR of data ^ parity bit) != `parity_odd`.
    - `rx_done` = 1.
- **Flag hold:** `data_out`, `frame_err` and `parity_err` hold until the next `rx_done`. A frame with errors still updates `data_out` and still pulses `rx_done`.
- **Reset:** `rst` low at any time, including mid-frame, immediately forces IDLE and clears every output, counter and shift register. A partial frame is discarded.

## Timing
- **Reset values:** `data_out`=0x00, `rx_done`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
- **Synchroniser latency:** 2 clocks from a pin change to `r_s`. Call E the first cycle with `r_s`=0 after a high.
- **Sample points:**
  - Start sample at E+8·DIV.
  - Data bit i (0..7) at E+(24+16i)·DIV.
  - Parity at E+152·DIV.
  - Stop at E+152·DIV without parity, E+168·DIV with parity.
- **`rx_done`:** high exactly 1 cycle, the cycle after the stop sample. `busy` falls on that same cycle.
- **Back-to-back frames:** a start edge arriving the cycle after the stop sample must be accepted. There is no dead time beyond edge detection.
- **Baud tolerance:** correct reception for a baud mismatch within ±3%.

## Test plan
- **Clean frame:** freq=16_000_000, baudrate=1_000_000 (DIV=1), send 0x5A with stop=1. Expect `rx_done` one cycle, `data_out`=0x5A, `frame_err`=0, `busy` high throughout the frame.
- **Glitch rejection:** drive `r` low for 4 cycles, then high. Expect no `rx_done`, `busy` back to 0 by E+9, `data_out` unchanged.
- **Framing error:** send 0x3C with stop bit 0. Expect `rx_done` pulse, `data_out`=0x3C, `frame_err`=1. Then hold `r` low 300 cycles: expect no new frame until `r` rises and falls again.
- **Parity:** with `parity_en`=1, `parity_odd`=0:
  - 0x07 with parity 1: expect `parity_err`=0.
  - 0x07 with parity 0: expect `parity_err`=1.
  - Repeat with `parity_odd`=1 and confirm the result inverts.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap. Expect two `rx_done` pulses exactly 160 cycles apart, with `data_out` 0x00 then 0xFF.
- **Reset mid-frame:** pulse `rst` low during bit 3 of 0xA5, then send 0x81. Expect outputs cleared during reset, no `rx_done` for the aborted frame, and a subsequent correct 0x81 reception.
